// File: rtl/imm_generator.sv
// RV32I immediate generator: combinational field extraction and extension,
// plus an enable-gated registered copy for trace and pipelined consumers.
module imm_generator (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  ImmSrc,
  input  logic [31:0] instruction,
  output logic [31:0] Imm_ext,
  output logic [31:0] Imm_ext_q,
  output logic        ImmSrc_err,
  output logic        ImmSrc_err_q
);

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_U     = 3'b010;
  localparam logic [2:0] IMM_SHAMT = 3'b011;
  localparam logic [2:0] IMM_B     = 3'b101;
  localparam logic [2:0] IMM_J     = 3'b110;

  logic [31:0] w_imm;
  logic        w_err;
  logic        w_sign;
  logic [31:0] r_imm_q;
  logic        r_err_q;

  // Every format sign-extends from bit 31, whatever bit lands at the field's MSB.
  assign w_sign = instruction[31];

  always_comb begin
    w_imm = 32'h0;
    w_err = 1'b0;
    case (ImmSrc)
      IMM_I:     w_imm = {{20{w_sign}}, instruction[31:20]};
      IMM_S:     w_imm = {{20{w_sign}}, instruction[31:25], instruction[11:7]};
      IMM_U:     w_imm = {instruction[31:12], 12'b0};
      IMM_SHAMT: w_imm = {27'b0, instruction[24:20]};
      IMM_B:     w_imm = {{19{w_sign}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
      IMM_J:     w_imm = {{11{w_sign}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
      default: begin
        w_imm = 32'h0;
        w_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_imm_q <= 32'h0;
      r_err_q <= 1'b0;
    end else if (en) begin
      r_imm_q <= w_imm;
      r_err_q <= w_err;
    end
  end

  assign Imm_ext      = w_imm;
  assign ImmSrc_err   = w_err;
  assign Imm_ext_q    = r_imm_q;
  assign ImmSrc_err_q = r_err_q;

endmodule

// File: tb/tb_imm_generator.sv
// Directed bench for imm_generator: expected immediates are queued by the
// driver and popped by a negedge monitor; a small model tracks the registers.
module tb_imm_generator;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  ImmSrc;
  logic [31:0] instruction;
  logic [31:0] Imm_ext;
  logic [31:0] Imm_ext_q;
  logic        ImmSrc_err;
  logic        ImmSrc_err_q;

  imm_generator dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ImmSrc       (ImmSrc),
    .instruction  (instruction),
    .Imm_ext      (Imm_ext),
    .Imm_ext_q    (Imm_ext_q),
    .ImmSrc_err   (ImmSrc_err),
    .ImmSrc_err_q (ImmSrc_err_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: {err, imm}
  logic [32:0] exp_q[$];
  logic [32:0] cur_exp;
  logic [32:0] model_q;
  logic        model_ok;
  logic        stim_valid;
  int          n_checks;
  int          n_fail;

  // Register model driven from bench-side expectations, never from the DUT.
  always @(posedge clk) begin
    if (rst) begin
      model_q  <= 33'h0;
      model_ok <= 1'b1;
    end else if (en) begin
      model_q  <= cur_exp;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (stim_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("imm_ext", Imm_ext, e[31:0]);
      check("immsrc_err", {31'b0, ImmSrc_err}, {31'b0, e[32]});
    end
    if (model_ok) begin
      check("imm_ext_q", Imm_ext_q, model_q[31:0]);
      check("immsrc_err_q", {31'b0, ImmSrc_err_q}, {31'b0, model_q[32]});
    end
  end

  // driver
  task automatic drive(input logic r, input logic e, input logic [2:0] src,
                       input logic [31:0] instr, input logic [31:0] exp_imm,
                       input logic exp_err);
    @(posedge clk);
    #1;
    rst         = r;
    en          = e;
    ImmSrc      = src;
    instruction = instr;
    cur_exp     = {exp_err, exp_imm};
    exp_q.push_back({exp_err, exp_imm});
    stim_valid  = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    stim_valid  = 1'b0;
    model_ok    = 1'b0;
    model_q     = 33'h0;
    cur_exp     = 33'h0;
    rst         = 1'b1;
    en          = 1'b0;
    ImmSrc      = 3'b000;
    instruction = 32'h0;

    // reset edge with a live I-type on the combinational path
    drive(1'b1, 1'b0, 3'b000, 32'h06410093, 32'd100,        1'b0);
    // loads, one per edge
    drive(1'b0, 1'b1, 3'b000, 32'hFF442383, 32'hFFFFFFF4,   1'b0);
    drive(1'b0, 1'b1, 3'b001, 32'h00B62A23, 32'd20,         1'b0);
    drive(1'b0, 1'b1, 3'b001, 32'hFED72C23, 32'hFFFFFFF8,   1'b0);
    drive(1'b0, 1'b1, 3'b101, 32'h01288263, 32'd4,          1'b0);
    drive(1'b0, 1'b1, 3'b101, 32'hFF4998E3, 32'hFFFFFFF0,   1'b0);
    drive(1'b0, 1'b1, 3'b110, 32'h014000EF, 32'd20,         1'b0);
    drive(1'b0, 1'b1, 3'b110, 32'hFF9FF0EF, 32'hFFFFFFF8,   1'b0);
    drive(1'b0, 1'b1, 3'b010, 32'hABCDE037, 32'hABCDE000,   1'b0);
    drive(1'b0, 1'b1, 3'b011, 32'hFFF01013, 32'h0000001F,   1'b0);
    drive(1'b0, 1'b1, 3'b100, 32'hFFFFFFFF, 32'h0,          1'b1);
    drive(1'b0, 1'b1, 3'b111, 32'hFFFFFFFF, 32'h0,          1'b1);
    // opcode bits must not matter
    drive(1'b0, 1'b1, 3'b000, 32'h06410000, 32'd100,        1'b0);
    drive(1'b0, 1'b1, 3'b000, 32'hFF442383, 32'hFFFFFFF4,   1'b0);
    // hold: inputs move, enable low
    drive(1'b0, 1'b0, 3'b010, 32'hABCDE037, 32'hABCDE000,   1'b0);
    drive(1'b0, 1'b0, 3'b111, 32'h12345678, 32'h0,          1'b1);
    drive(1'b0, 1'b0, 3'b011, 32'h00A00013, 32'h0000000A,   1'b0);
    // load an error flag, then reset wins over enable
    drive(1'b0, 1'b1, 3'b100, 32'h0,        32'h0,          1'b1);
    drive(1'b1, 1'b1, 3'b110, 32'hFF9FF0EF, 32'hFFFFFFF8,   1'b0);
    drive(1'b0, 1'b0, 3'b000, 32'h7FF00013, 32'h000007FF,   1'b0);
    drive(1'b0, 1'b1, 3'b001, 32'h80000000, 32'hFFFFF800,   1'b0);
    drive(1'b0, 1'b0, 3'b001, 32'h80000000, 32'hFFFFF800,   1'b0);

    // bounded drain of the expected queue
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
